// File: rtl/conv_scan_ctrl_pkg.sv
// Shared definitions for the 3x3 convolution scan path: scan FSM states,
// default map geometry shared with the address generator and pixel buffer.
package conv_scan_ctrl_pkg;

  localparam int unsigned DEF_OUT_DIM = 28;
  localparam int unsigned DEF_POS_W   = 5;
  localparam int unsigned STALL_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    ISSUE,
    WAIT,
    HANDOFF,
    DONE
  } scan_state_t;

  // Counter width able to hold a latency value (never narrower than 1 bit).
  function automatic int unsigned lat_width(input int unsigned lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/conv_scan_ctrl_if.sv
// Scan-controller bus: layer start/done, MAC handoff, address-generator drive.
// Optional stall_cnt member exists only when CONV_SCAN_STALL_CNT_EN is defined.
interface conv_scan_ctrl_if
  import conv_scan_ctrl_pkg::*;
#(
  parameter int unsigned POS_W = DEF_POS_W
) ();

  logic             start;
  logic             mac_ready;
  logic [POS_W-1:0] i;
  logic [POS_W-1:0] j;
  logic             addr_gen;
  logic             row_start;
  logic             patch_valid;
  logic             busy;
  logic             done;
`ifdef CONV_SCAN_STALL_CNT_EN
  logic [STALL_W-1:0] stall_cnt;
`endif

  modport master (
    input  start, mac_ready,
    output i, j, addr_gen, row_start, patch_valid, busy, done
`ifdef CONV_SCAN_STALL_CNT_EN
    , output stall_cnt
`endif
  );

  modport slave (
    output start, mac_ready,
    input  i, j, addr_gen, row_start, patch_valid, busy, done
`ifdef CONV_SCAN_STALL_CNT_EN
    , input stall_cnt
`endif
  );

endinterface

// File: rtl/conv_scan_lat_cnt.sv
// Latency down-counter: loaded with a cycle count, decremented on request.
// zero is asserted when the count is zero or reaches zero at the coming edge,
// so a consumer stepping on zero spends exactly load_val decrement cycles.
module conv_scan_lat_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Count register: load has priority over decrement; holds at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0) || (dec && (cnt == W'(1)));

endmodule

// File: rtl/conv_scan_ctrl.sv
// Convolution scan controller: walks (i, j) over an OUT_DIM x OUT_DIM output
// map, strobes the patch address generator, waits out address + BRAM latency
// and hands each patch to the MAC stage with a valid/ready handshake.
// Optional feature macro: CONV_SCAN_STALL_CNT_EN (saturating MAC stall counter).
module conv_scan_ctrl
  import conv_scan_ctrl_pkg::*;
#(
  parameter int unsigned OUT_DIM  = DEF_OUT_DIM,
  parameter int unsigned ADDR_LAT = 1,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned POS_W    = DEF_POS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_scan_ctrl_if.master      bus
);

  localparam int unsigned      LAT      = ADDR_LAT + RD_LAT;
  localparam int unsigned      LAT_W    = lat_width(LAT);
  localparam logic [LAT_W-1:0] LAT_VAL  = LAT_W'(LAT);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(OUT_DIM - 1);

  scan_state_t      state, state_n;
  logic [POS_W-1:0] i_q, j_q;
  logic             launch, accept;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic             addr_gen, row_start, patch_valid, busy, done;

  assign launch = (state == IDLE) && bus.start;
  assign accept = (state == HANDOFF) && bus.mac_ready;

  conv_scan_lat_cnt #(
    .W (LAT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Position register: moves only on start or on MAC acceptance, never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q <= '0;
      j_q <= '0;
    end else if (launch) begin
      i_q <= '0;
      j_q <= '0;
    end else if (accept) begin
      if (j_q < LAST_POS) begin
        j_q <= j_q + 1'b1;
      end else if (i_q < LAST_POS) begin
        j_q <= '0;
        i_q <= i_q + 1'b1;
      end
    end
  end

  // Next-state and Moore outputs. Row starts go through PRIME because the
  // generator's full-patch flag lags one strobe, so they need two strobes.
  always_comb begin
    state_n     = state;
    addr_gen    = 1'b0;
    row_start   = 1'b0;
    patch_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_n = PRIME;
      end
      PRIME: begin
        busy     = 1'b1;
        addr_gen = 1'b1;
        state_n  = ISSUE;
      end
      ISSUE: begin
        busy     = 1'b1;
        addr_gen = 1'b1;
        cnt_load = 1'b1;
        if (LAT == 0) state_n = HANDOFF;
        else          state_n = WAIT;
      end
      WAIT: begin
        busy    = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero) state_n = HANDOFF;
      end
      HANDOFF: begin
        busy        = 1'b1;
        patch_valid = 1'b1;
        row_start   = (j_q == '0);
        if (bus.mac_ready) begin
          if (j_q < LAST_POS)      state_n = ISSUE;
          else if (i_q < LAST_POS) state_n = PRIME;
          else                     state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.i           = i_q;
  assign bus.j           = j_q;
  assign bus.addr_gen    = addr_gen;
  assign bus.row_start   = row_start;
  assign bus.patch_valid = patch_valid;
  assign bus.busy        = busy;
  assign bus.done        = done;

`ifdef CONV_SCAN_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q;

  // Saturating count of HANDOFF cycles the MAC refused; cleared on start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (launch) begin
      stall_q <= '0;
    end else if ((state == HANDOFF) && !bus.mac_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Bench for conv_scan_ctrl: a 4x4 instance for directed scenarios and a 28x28
// instance for a randomized-backpressure pass, checked by a rule-based
// scoreboard (row-major order, strobe counts, latency, hold, busy window).
module tb_conv_scan_ctrl;
  import conv_scan_ctrl_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tb_start = 1'b0;
  logic tb_ready = 1'b1;
  logic sel = 1'b0;

  conv_scan_ctrl_if #(.POS_W(5)) bus4 ();
  conv_scan_ctrl_if #(.POS_W(5)) bus28 ();

  assign bus4.start      = tb_start && !sel;
  assign bus28.start     = tb_start && sel;
  assign bus4.mac_ready  = tb_ready;
  assign bus28.mac_ready = tb_ready;

  conv_scan_ctrl #(.OUT_DIM(4), .ADDR_LAT(1), .RD_LAT(1), .POS_W(5)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.master));
  conv_scan_ctrl #(.OUT_DIM(28), .ADDR_LAT(1), .RD_LAT(1), .POS_W(5)) dut28 (
    .clk(clk), .rst(rst), .bus(bus28.master));

  always #5 clk = ~clk;

  // Observed instance selected by sel.
  logic [4:0] m_i, m_j;
  logic m_addr_gen, m_row_start, m_patch_valid, m_busy, m_done;
  assign m_i           = sel ? bus28.i : bus4.i;
  assign m_j           = sel ? bus28.j : bus4.j;
  assign m_addr_gen    = sel ? bus28.addr_gen : bus4.addr_gen;
  assign m_row_start   = sel ? bus28.row_start : bus4.row_start;
  assign m_patch_valid = sel ? bus28.patch_valid : bus4.patch_valid;
  assign m_busy        = sel ? bus28.busy : bus4.busy;
  assign m_done        = sel ? bus28.done : bus4.done;

  // Scoreboard state (written only by the monitor).
  int cyc = 0;
  int acc_k = 0, run = 0, last_strobe = 0, done_cyc = 0;
  int n_strobe = 0, n_valid = 0, n_accept = 0, n_stall = 0, n_done = 0;
  int err_seq = 0, err_tim = 0, err_misc = 0;
  logic pass_armed = 1'b0, in_valid = 1'b0;
  logic [4:0] held_i = '0, held_j = '0;
  logic held_rs = 1'b0;

  int n_dim, exp_i, exp_j;
  assign n_dim = sel ? 28 : 4;
  assign exp_i = acc_k / n_dim;
  assign exp_j = acc_k % n_dim;

  always @(posedge clk) cyc <= cyc + 1;

  // Rule violations for the current cycle.
  logic first_valid;
  int d_seq, d_tim, d_misc;
  always_comb begin
    first_valid = m_patch_valid && !in_valid;
    d_seq = 0;
    d_tim = 0;
    d_misc = 0;
    if (m_addr_gen && (int'(m_i) != exp_i || int'(m_j) != exp_j)) d_seq = d_seq + 1;
    if (m_patch_valid && (int'(m_i) != exp_i || int'(m_j) != exp_j)) d_seq = d_seq + 1;
    if (m_patch_valid && (m_row_start != (exp_j == 0))) d_seq = d_seq + 1;
    if (first_valid && run != ((exp_j == 0) ? 2 : 1)) d_seq = d_seq + 1;
    if (m_addr_gen && run > 0 && cyc != last_strobe + 1) d_seq = d_seq + 1;
    if (m_addr_gen && m_patch_valid) d_tim = d_tim + 1;
    if (first_valid && cyc != last_strobe + 1 + LAT) d_tim = d_tim + 1;
    if (m_patch_valid && in_valid &&
        (m_i != held_i || m_j != held_j || m_row_start != held_rs)) d_tim = d_tim + 1;
    if (int'(m_i) > n_dim - 1 || int'(m_j) > n_dim - 1) d_misc = d_misc + 1;
    if (pass_armed && !m_done && !m_busy) d_misc = d_misc + 1;
    if (m_done && (m_busy || !pass_armed)) d_misc = d_misc + 1;
    if (m_addr_gen && !m_busy) d_misc = d_misc + 1;
  end

  // Monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      pass_armed <= 1'b0;
      in_valid   <= 1'b0;
      run        <= 0;
      acc_k      <= 0;
    end else if (tb_start && !m_busy && !m_done) begin
      pass_armed <= 1'b1;
      in_valid   <= 1'b0;
      run        <= 0;
      acc_k      <= 0;
    end else begin
      err_seq  <= err_seq + d_seq;
      err_tim  <= err_tim + d_tim;
      err_misc <= err_misc + d_misc;
      if (m_addr_gen) begin
        n_strobe    <= n_strobe + 1;
        run         <= run + 1;
        last_strobe <= cyc;
      end
      if (m_patch_valid) begin
        n_valid <= n_valid + 1;
        held_i  <= m_i;
        held_j  <= m_j;
        held_rs <= m_row_start;
        if (tb_ready) begin
          n_accept <= n_accept + 1;
          acc_k    <= acc_k + 1;
          run      <= 0;
          in_valid <= 1'b0;
        end else begin
          n_stall  <= n_stall + 1;
          in_valid <= 1'b1;
        end
      end
      if (m_done) begin
        n_done     <= n_done + 1;
        done_cyc   <= cyc;
        pass_armed <= 1'b0;
      end
    end
  end

  // Checking and stimulus.
  int n_tests = 0, n_fail = 0;
  int s_strobe, s_valid, s_accept, s_stall, s_done, s_seq, s_tim, s_misc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tb_start = 1'b1;
    tick();
    tb_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (m_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strobe(input int wi, input int wj, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (m_addr_gen && int'(m_i) == wi && int'(m_j) == wj) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic begin_phase();
    s_strobe = n_strobe; s_valid = n_valid; s_accept = n_accept; s_stall = n_stall;
    s_done = n_done; s_seq = err_seq; s_tim = err_tim; s_misc = err_misc;
  endtask

  // Called in the done cycle; steps one cycle so the monitor has seen it.
  task automatic end_phase(input string tag, input int exp_strobe, input int exp_accept);
    tick();
    check({tag, "_done_pulse"}, 32'(m_done), 32'd0);
    check({tag, "_busy_after"}, 32'(m_busy), 32'd0);
    check({tag, "_strobes"}, 32'(n_strobe - s_strobe), 32'(exp_strobe));
    check({tag, "_accepts"}, 32'(n_accept - s_accept), 32'(exp_accept));
    check({tag, "_valid_cycles"}, 32'(n_valid - s_valid), 32'(exp_accept + n_stall - s_stall));
    check({tag, "_done_count"}, 32'(n_done - s_done), 32'd1);
    check({tag, "_order_errs"}, 32'(err_seq - s_seq), 32'd0);
    check({tag, "_timing_errs"}, 32'(err_tim - s_tim), 32'd0);
    check({tag, "_range_busy_errs"}, 32'(err_misc - s_misc), 32'd0);
  endtask

  initial begin
    bit ok;

    // Reset state
    #3;
    check("rst_i", 32'(bus4.i), 32'd0);
    check("rst_j", 32'(bus4.j), 32'd0);
    check("rst_addr_gen", 32'(bus4.addr_gen), 32'd0);
    check("rst_row_start", 32'(bus4.row_start), 32'd0);
    check("rst_patch_valid", 32'(bus4.patch_valid), 32'd0);
    check("rst_busy", 32'(bus4.busy), 32'd0);
    check("rst_done", 32'(bus4.done), 32'd0);
    check("rst_busy28", 32'(bus28.busy), 32'd0);
`ifdef CONV_SCAN_STALL_CNT_EN
    check("rst_stall_cnt", 32'(bus4.stall_cnt), 32'd0);
`endif
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // Undisturbed 4x4 pass
    begin_phase();
    pulse_start();
    wait_done(200, ok);
    check("a_done_seen", 32'(ok), 32'd1);
    end_phase("a", 20, 16);
    check("a_done_after_issue", 32'(done_cyc - last_strobe), 32'd4);
`ifdef CONV_SCAN_STALL_CNT_EN
    check("a_stall_cnt", 32'(bus4.stall_cnt), 32'd0);
`endif

    // Backpressure at (2,1)
    begin_phase();
    pulse_start();
    wait_strobe(2, 1, 200, ok);
    check("b_strobe_21", 32'(ok), 32'd1);
    tb_ready = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_patch_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("b_valid_seen", 32'(ok), 32'd1);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      check("b_hold_valid", 32'(m_patch_valid), 32'd1);
      check("b_hold_i", 32'(m_i), 32'd2);
      check("b_hold_j", 32'(m_j), 32'd1);
      check("b_hold_no_strobe", 32'(m_addr_gen), 32'd0);
    end
    tick();
    tb_ready = 1'b1;
    wait_strobe(2, 2, 4, ok);
    check("b_advance_22", 32'(ok), 32'd1);
    wait_done(200, ok);
    check("b_done_seen", 32'(ok), 32'd1);
    end_phase("b", 20, 16);
    check("b_stall_cycles", 32'(n_stall - s_stall), 32'd7);
`ifdef CONV_SCAN_STALL_CNT_EN
    check("b_stall_cnt", 32'(bus4.stall_cnt), 32'd7);
`endif

    // start while busy at (1,2)
    begin_phase();
    pulse_start();
    wait_strobe(1, 2, 200, ok);
    check("c_strobe_12", 32'(ok), 32'd1);
    pulse_start();
    wait_done(200, ok);
    check("c_done_seen", 32'(ok), 32'd1);
    end_phase("c", 20, 16);

    // Reset during WAIT at (2,3), then a fresh pass
    begin_phase();
    pulse_start();
    wait_strobe(2, 3, 200, ok);
    check("d_strobe_23", 32'(ok), 32'd1);
    tick();
    check("d_pre_busy", 32'(m_busy), 32'd1);
    check("d_pre_i", 32'(m_i), 32'd2);
    check("d_pre_j", 32'(m_j), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("d_async_i", 32'(m_i), 32'd0);
    check("d_async_j", 32'(m_j), 32'd0);
    check("d_async_busy", 32'(m_busy), 32'd0);
    check("d_async_addr_gen", 32'(m_addr_gen), 32'd0);
    check("d_async_valid", 32'(m_patch_valid), 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("d_idle_busy", 32'(m_busy), 32'd0);
    check("d_no_done", 32'(n_done - s_done), 32'd0);
    begin_phase();
    pulse_start();
    wait_done(200, ok);
    check("d_done_seen", 32'(ok), 32'd1);
    end_phase("d", 20, 16);

    // 28x28 pass with random backpressure
    sel = 1'b1;
    tb_ready = 1'b1;
    tick();
    begin_phase();
    pulse_start();
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      tick();
      if (m_done) begin
        ok = 1'b1;
        break;
      end
      tb_ready = 1'($urandom_range(0, 1));
    end
    check("e_done_seen", 32'(ok), 32'd1);
    end_phase("e", 812, 784);
`ifdef CONV_SCAN_STALL_CNT_EN
    check("e_stall_cnt", 32'(bus28.stall_cnt), 32'(n_stall - s_stall));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
